// File: rtl/cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : cpu_multicycle
// Brief    : Multi-cycle 24-bit-instruction CPU with loadable instruction
//            memory, register file (R0 = 0), start/halt run control and a
//            retired-instruction counter. Define CPU_MC_BNE_EN to enable BNE.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_multicycle #(
    parameter int DATA_W     = 8,
    parameter int NREG       = 16,
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [23:0]                   imem_wdata,
    input  logic                          start,
    output logic                          busy,
    output logic                          halted,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [DATA_W-1:0]             ALUResult,
    output logic [DATA_W-1:0]             cpu_out,
    output logic [15:0]                   retired
);

    localparam int c_PC_W = $clog2(IMEM_DEPTH);
    localparam int c_RI_W = $clog2(NREG);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FETCH     = 3'd1;
    localparam logic [2:0] c_S_DECODE    = 3'd2;
    localparam logic [2:0] c_S_EXECUTE   = 3'd3;
    localparam logic [2:0] c_S_WRITEBACK = 3'd4;
    localparam logic [2:0] c_S_HALTED    = 3'd5;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_ADDI = 4'h4;
    localparam logic [3:0] c_OP_BEQ  = 4'h5;
    localparam logic [3:0] c_OP_JMP  = 4'h6;
    localparam logic [3:0] c_OP_HALT = 4'h7;
    localparam logic [3:0] c_OP_XOR  = 4'h8;
    localparam logic [3:0] c_OP_SHL  = 4'h9;
`ifdef CPU_MC_BNE_EN
    localparam logic [3:0] c_OP_BNE  = 4'hB;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [23:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [NREG];
    logic [23:0]       r_instr;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;

    logic [3:0]        w_op;
    logic [c_RI_W-1:0] w_rd;
    logic [c_RI_W-1:0] w_rs1;
    logic [c_RI_W-1:0] w_rs2;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    logic [c_PC_W-1:0] w_target;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_alu;
    logic              w_is_alu;
    logic              w_taken;
    logic              w_is_halt;
    logic              w_ctrl_idle;

    assign w_op      = r_instr[23:20];
    assign w_rd      = r_instr[16 +: c_RI_W];
    assign w_rs1     = r_instr[12 +: c_RI_W];
    assign w_rs2     = r_instr[8 +: c_RI_W];
    assign w_imm     = r_instr[7:0];
    assign w_imm_ext = DATA_W'(w_imm);
    assign w_target  = w_imm[c_PC_W-1:0];
    assign w_is_halt = (w_op == c_OP_HALT);

    assign w_rdata_a = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rdata_b = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    assign w_ctrl_idle = (r_state == c_S_IDLE) || (r_state == c_S_HALTED);
    assign busy        = (r_state == c_S_FETCH) || (r_state == c_S_DECODE) ||
                         (r_state == c_S_EXECUTE) || (r_state == c_S_WRITEBACK);
    assign halted      = (r_state == c_S_HALTED);

    always_comb begin
        w_is_alu = 1'b1;
        w_alu    = '0;
        case (w_op)
            c_OP_ADD:  w_alu = r_op_a + r_op_b;
            c_OP_SUB:  w_alu = r_op_a - r_op_b;
            c_OP_AND:  w_alu = r_op_a & r_op_b;
            c_OP_OR:   w_alu = r_op_a | r_op_b;
            c_OP_XOR:  w_alu = r_op_a ^ r_op_b;
            c_OP_ADDI: w_alu = r_op_a + w_imm_ext;
            c_OP_SHL:  w_alu = r_op_a << 1;
            default:   w_is_alu = 1'b0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            c_OP_BEQ: w_taken = (r_op_a == r_op_b);
            c_OP_JMP: w_taken = 1'b1;
`ifdef CPU_MC_BNE_EN
            c_OP_BNE: w_taken = (r_op_a != r_op_b);
`endif
            default:  w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE, c_S_HALTED: if (start) w_next_state = c_S_FETCH;
            c_S_FETCH:            w_next_state = c_S_DECODE;
            c_S_DECODE:           w_next_state = c_S_EXECUTE;
            c_S_EXECUTE: begin
                if (w_is_alu)       w_next_state = c_S_WRITEBACK;
                else if (w_is_halt) w_next_state = c_S_HALTED;
                else                w_next_state = c_S_FETCH;
            end
            c_S_WRITEBACK:        w_next_state = c_S_FETCH;
            default:              w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) r_state <= c_S_IDLE;
        else       r_state <= w_next_state;
    end

    // Memory is not reset; a write in the same cycle as start lands before FETCH.
    always_ff @(posedge CLK) begin
        if (!reset && imem_we && w_ctrl_idle) r_imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc        <= '0;
            ALUResult <= '0;
            cpu_out   <= '0;
            retired   <= '0;
            r_instr   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_HALTED: if (start) pc <= '0;
                c_S_FETCH:  r_instr <= r_imem[pc];
                c_S_DECODE: begin
                    r_op_a <= w_rdata_a;
                    r_op_b <= w_rdata_b;
                end
                c_S_EXECUTE: begin
                    if (w_is_alu) begin
                        ALUResult <= w_alu;
                    end else begin
                        retired <= retired + 16'd1;
                        if (!w_is_halt) pc <= w_taken ? w_target : pc + 1'b1;
                    end
                end
                c_S_WRITEBACK: begin
                    if (w_rd != '0) r_regs[w_rd] <= ALUResult;
                    cpu_out <= ALUResult;
                    pc      <= pc + 1'b1;
                    retired <= retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
